// File: rtl/resp_encode.sv
// resp_encode: frames FIFO read data as HEAD, payload bytes, optional XOR checksum, TAIL.
// Define RESP_CHECKSUM_EN to insert the payload XOR byte between the last payload byte and TAIL.
module resp_encode #(
  parameter int unsigned BURST_LEN = 4,
  parameter logic [7:0]  HEAD      = 8'h55,
  parameter logic [7:0]  TAIL      = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       rfifo_empty,
  output logic       rfifo_rd_en,
  input  logic [7:0] rfifo_data,
  input  logic       tx_busy,
  output logic       tx_trig,
  output logic [7:0] tx_data,
  output logic       frame_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD  = 3'd1,
    S_FETCH = 3'd2,
    S_LATCH = 3'd3,
    S_DATA  = 3'd4,
    S_TAIL  = 3'd5
`ifdef RESP_CHECKSUM_EN
    ,
    S_CKSUM = 3'd6
`endif
  } state_t;

`ifdef RESP_CHECKSUM_EN
  localparam state_t S_AFTER = S_CKSUM;
`else
  localparam state_t S_AFTER = S_TAIL;
`endif

  localparam logic [7:0] LAST  = BURST_LEN[7:0];
  localparam logic [1:0] GUARD = 2'd1;

  state_t     state;
  state_t     state_n;
  logic [7:0] hold;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [1:0] guard;
  logic       can_issue;
  logic       issue;
  logic       rd_go;
  logic       last;
  logic [7:0] tx_byte;
`ifdef RESP_CHECKSUM_EN
  logic [7:0] cksum;
`endif

  // guard blocks the cycle right after a trigger, before uart_tx raises busy
  assign can_issue = !tx_busy && (guard == 2'd0);
  assign cnt_nxt   = cnt + 8'd1;
  assign last      = (cnt_nxt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (frame_start) state_n = S_HEAD;
      S_HEAD:  if (can_issue) state_n = S_FETCH;
      S_FETCH: if (!rfifo_empty) state_n = S_LATCH;
      S_LATCH: state_n = S_DATA;
      S_DATA: begin
        if (can_issue) state_n = last ? S_AFTER : S_FETCH;
      end
`ifdef RESP_CHECKSUM_EN
      S_CKSUM: if (can_issue) state_n = S_TAIL;
`endif
      S_TAIL:  if (can_issue) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    issue   = 1'b0;
    rd_go   = 1'b0;
    tx_byte = 8'h00;
    unique case (state)
      S_HEAD: begin
        issue   = can_issue;
        tx_byte = HEAD;
      end
      S_FETCH: rd_go = !rfifo_empty;
      S_DATA: begin
        issue   = can_issue;
        tx_byte = hold;
      end
`ifdef RESP_CHECKSUM_EN
      S_CKSUM: begin
        issue   = can_issue;
        tx_byte = cksum;
      end
`endif
      S_TAIL: begin
        issue   = can_issue;
        tx_byte = TAIL;
      end
      default: begin
        issue = 1'b0;
        rd_go = 1'b0;
      end
    endcase
  end

  // FIFO pops on this edge so its data is valid while in LATCH
  assign rfifo_rd_en = rd_go && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_trig    <= 1'b0;
      tx_data    <= 8'h00;
      guard      <= 2'd0;
      hold       <= 8'h00;
      cnt        <= 8'h00;
      frame_busy <= 1'b0;
    end else begin
      tx_trig <= issue;
      if (issue) begin
        tx_data <= tx_byte;
        guard   <= GUARD;
      end else if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end
      if (state == S_LATCH) hold <= rfifo_data;
      if (state == S_IDLE && frame_start) frame_busy <= 1'b1;
      if (issue && state == S_DATA) cnt <= cnt_nxt;
      if (issue && state == S_TAIL) begin
        cnt        <= 8'h00;
        frame_busy <= 1'b0;
      end
    end
  end

`ifdef RESP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cksum <= 8'h00;
    end else if (issue && state == S_HEAD) begin
      cksum <= 8'h00;
    end else if (issue && state == S_DATA) begin
      cksum <= cksum ^ hold;
    end
  end
`endif

endmodule

// File: tb/tb_resp_encode.sv
// tb_resp_encode: random and directed frames against a FIFO/UART model and a byte-list reference.
// Expected frames are built from payload lists: HEAD, payload, optional XOR, TAIL.
module tb_resp_encode;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       rfifo_empty;
  logic       rfifo_rd_en;
  logic [7:0] rfifo_data = 8'h00;
  logic       tx_busy;
  logic       tx_trig;
  logic [7:0] tx_data;
  logic       frame_busy;

  resp_encode #(.BURST_LEN(BL), .HEAD(8'h55), .TAIL(8'hAA)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .rfifo_empty (rfifo_empty),
    .rfifo_rd_en (rfifo_rd_en),
    .rfifo_data  (rfifo_data),
    .tx_busy     (tx_busy),
    .tx_trig     (tx_trig),
    .tx_data     (tx_data),
    .frame_busy  (frame_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;
  int         rd_cnt = 0;
  int         rd_bad = 0;
  assign rfifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rfifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (rfifo_empty) begin
        rd_bad <= rd_bad + 1;
      end else begin
        rfifo_data <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 6'd1;
      end
    end
  end

  logic [7:0] got [$];
  int         busy_len = 10;
  int         bcnt = 0;
  int         cyc = 0;
  int         last_trig = 0;
  bit         have_last = 1'b0;
  int         gap_bad = 0;
  assign tx_busy = (bcnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_trig) begin
      got.push_back(tx_data);
      if (have_last && (cyc - last_trig) < 2) gap_bad <= gap_bad + 1;
      last_trig <= cyc;
      have_last <= 1'b1;
      bcnt      <= busy_len;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  int passes = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 6'd1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 800) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s_timeout", tag), 32'(got.size() >= n), 32'd1);
  endtask

  function automatic void build(input logic [7:0] p [BL], output logic [7:0] e [$]);
    logic [7:0] x;
    x = 8'h00;
    e = {};
    e.push_back(8'h55);
    for (int i = 0; i < BL; i++) begin
      e.push_back(p[i]);
      x = x ^ p[i];
    end
`ifdef RESP_CHECKSUM_EN
    e.push_back(x);
`endif
    e.push_back(8'hAA);
  endfunction

  task automatic cmp_frame(input string tag, input int base, input logic [7:0] e [$]);
    logic [7:0] obs;
    for (int i = 0; i < e.size(); i++) begin
      obs = (base + i < got.size()) ? got[base+i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(e[i]));
    end
  endtask

  task automatic run_frame(input string tag, input int blen, input logic [7:0] p [BL],
                           input bit restart);
    logic [7:0] e [$];
    int base;
    int rd0;
    build(p, e);
    busy_len = blen;
    base     = got.size();
    rd0      = rd_cnt;
    for (int i = 0; i < BL; i++) push(p[i]);
    pulse_start();
    chk({tag, "_busy_set"}, 32'(frame_busy), 32'd1);
    if (restart) begin
      wait_bytes({tag, "_mid"}, base + 2);
      pulse_start();
    end
    wait_bytes(tag, base + e.size());
    @(negedge clk);
    chk({tag, "_busy_clr"}, 32'(frame_busy), 32'd0);
    cmp_frame(tag, base, e);
    repeat (restart ? 100 : 20) @(negedge clk);
    chk({tag, "_nbytes"}, 32'(got.size() - base), 32'(e.size()));
    chk({tag, "_rd_cnt"}, 32'(rd_cnt - rd0), 32'(BL));
  endtask

  initial begin
    logic [7:0] p [BL];
    logic [7:0] e [$];
    int base;
    int rd0;

    rst         = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(tx_trig), 32'd0);
    chk("rst_rd_en", 32'(rfifo_rd_en), 32'd0);
    chk("rst_busy", 32'(frame_busy), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    rst = 1'b1;

    p = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_frame("basic", 10, p, 1'b0);
    run_frame("nobusy", 0, p, 1'b0);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < BL; i++) p[i] = 8'($urandom);
      run_frame($sformatf("rand%0d", f), (f == 1) ? 0 : $urandom_range(2, 10), p, 1'b0);
    end

    for (int i = 0; i < BL; i++) p[i] = 8'($urandom);
    run_frame("restart", 10, p, 1'b1);

    p = '{8'h12, 8'h34, 8'h56, 8'h78};
    build(p, e);
    busy_len = 10;
    base     = got.size();
    rd0      = rd_cnt;
    push(p[0]);
    push(p[1]);
    pulse_start();
    wait_bytes("stall_pre", base + 3);
    repeat (50) @(negedge clk);
    chk("stall_no_trig", 32'(got.size() - base), 32'd3);
    chk("stall_rd_cnt", 32'(rd_cnt - rd0), 32'd2);
    chk("stall_busy", 32'(frame_busy), 32'd1);
    push(p[2]);
    push(p[3]);
    wait_bytes("stall", base + e.size());
    @(negedge clk);
    cmp_frame("stall", base, e);
    chk("stall_rd_total", 32'(rd_cnt - rd0), 32'(BL));

    for (int i = 0; i < BL; i++) p[i] = 8'($urandom);
    base = got.size();
    for (int i = 0; i < BL; i++) push(p[i]);
    pulse_start();
    wait_bytes("abort_pre", base + 3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_trig", 32'(tx_trig), 32'd0);
    chk("abort_busy", 32'(frame_busy), 32'd0);
    chk("abort_rd_en", 32'(rfifo_rd_en), 32'd0);
    chk("abort_data", 32'(tx_data), 32'd0);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("abort_no_resume", 32'(got.size() - base), 32'd3);
    wr_ptr = rd_ptr;
    for (int i = 0; i < BL; i++) p[i] = 8'($urandom);
    run_frame("after_abort", 10, p, 1'b0);

    chk("gap_violations", 32'(gap_bad), 32'd0);
    chk("rd_while_empty", 32'(rd_bad), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/resp_encode.md
RESP_ENCODE -- requirements
Module: resp_encode

Interface
REQ-001 The module SHALL have parameter BURST_LEN, default 4, giving the payload bytes per frame (legal 1..255).
REQ-002 The module SHALL have parameter HEAD, default 8'h55, giving the frame header byte.
REQ-003 The module SHALL have parameter TAIL, default 8'hAA, giving the frame tail byte.
REQ-004 The module SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 The module SHALL have port rst  input  1  synchronous active-low reset.
REQ-006 The module SHALL have port frame_start  input  1  one-cycle pulse requesting one response frame.
REQ-007 The module SHALL have port rfifo_empty  input  1  read-data FIFO empty flag.
REQ-008 The module SHALL have port rfifo_rd_en  output  1  FIFO read strobe; data is valid on rfifo_data the following cycle.
REQ-009 The module SHALL have port rfifo_data  input  8  FIFO read data.
REQ-010 The module SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-011 The module SHALL have port tx_trig  output  1  one-cycle pulse launching tx_data on the UART.
REQ-012 The module SHALL have port tx_data  output  8  byte to transmit, held stable until the next tx_trig.
REQ-013 The module SHALL have port frame_busy  output  1  high from acceptance of frame_start until the tail byte is issued.

Function
REQ-014 The FSM SHALL have the states IDLE, HEAD, FETCH, LATCH, DATA, CKSUM and TAIL.
REQ-015 In IDLE, frame_start=1 SHALL move the FSM to HEAD and set frame_busy on the next cycle; frame_start outside IDLE SHALL be ignored.
REQ-016 A byte SHALL be issued only when tx_busy=0 and at least 2 cycles have passed since the previous tx_trig (guard for uart_tx busy latency).
REQ-017 Issuing a byte SHALL pulse tx_trig for exactly 1 cycle and register tx_data in that same cycle.
REQ-018 HEAD SHALL issue HEAD and then go to FETCH.
REQ-019 FETCH SHALL wait while rfifo_empty=1; when rfifo_empty=0, it SHALL pulse rfifo_rd_en for 1 cycle and go to LATCH.
REQ-020 LATCH SHALL capture rfifo_data into a holding register and go to DATA.
REQ-021 DATA SHALL issue the held byte and increment an 8-bit payload counter.
REQ-022 When the payload counter equals BURST_LEN, DATA SHALL go to CKSUM (macro defined) or TAIL (macro undefined); otherwise it SHALL go to FETCH.
REQ-023 TAIL SHALL issue TAIL, clear frame_busy, clear the counter and return to IDLE in the cycle after its tx_trig.
REQ-024 rfifo_rd_en SHALL assert exactly BURST_LEN times per frame and never while rfifo_empty=1.
REQ-025 A FIFO underflow (rfifo_empty=1 mid-frame) SHALL stall the frame indefinitely with no byte skipped or duplicated.
REQ-026 tx_trig and rfifo_rd_en SHALL NOT both be driven by the same state in the same cycle; every frame SHALL contain exactly BURST_LEN+2 bytes (BURST_LEN+3 with checksum).

Reset
REQ-027 While rst=0 at a clock edge, the FSM SHALL go to IDLE, and tx_trig, rfifo_rd_en and frame_busy SHALL be 0.
REQ-028 While rst=0 at a clock edge, tx_data, the holding register, the counter, the checksum and the guard counter SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; no further bytes SHALL be issued and no resume SHALL occur after release.
REQ-030 The first frame_start sampled after rst returns to 1 SHALL be accepted.

Configuration
REQ-031 When macro RESP_CHECKSUM_EN is defined, an 8-bit XOR of all payload bytes SHALL be accumulated (cleared at HEAD) and issued in CKSUM between the last payload byte and TAIL.
REQ-032 When RESP_CHECKSUM_EN is undefined, CKSUM and the accumulator SHALL be absent and DATA SHALL go directly to TAIL.

Verification
REQ-033 Scenario: FIFO preloaded 12 34 56 78, BURST_LEN=4, one frame_start, tx_busy held 10 cycles per byte -> tx_data sequence 55 12 34 56 78 AA, 6 tx_trig pulses, 4 rfifo_rd_en pulses.
REQ-034 Scenario: same stimulus as REQ-033 with RESP_CHECKSUM_EN defined -> tx_data sequence 55 12 34 56 78 08 AA (08 = 12^34^56^78).
REQ-035 Scenario: FIFO empty after 2 bytes for 50 cycles, then refilled with 56 78 -> output stalls after 34 with no tx_trig during the stall, then completes 56 78 AA.
REQ-036 Scenario: frame_start pulsed again during an active frame -> ignored; exactly one frame is sent.
REQ-037 Scenario: rst driven to 0 for 1 cycle after the second payload byte -> tx_trig stays 0, frame_busy=0, and a new frame_start then produces a full frame starting with 55.
REQ-038 Scenario: tx_busy tied to 0 -> issued bytes spaced by at least 2 cycles and the sequence is otherwise identical to REQ-033.
